spi_client_framed: RTL and testbench
====================================

SPI_CLIENT_FRAMED -- requirements
Module: spi_client_framed

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per word (legal 4..32).
REQ-002 SHALL have parameter CPOL, default 0, SPI clock idle level.
REQ-003 SHALL have parameter CPHA, default 0; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth (legal 2..3).
REQ-005 SHALL have one clock and an asynchronous, active-low reset, with ports as listed below (clock and reset first).
REQ-006 clk  in  1  system clock; at least 4x spi_clk frequency.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 spi_clk  in  1  SPI serial clock from controller.
REQ-009 mosi  in  1  controller-to-client data.
REQ-010 cs_n  in  1  chip select, active low.
REQ-011 miso  out  1  client-to-controller data, MSB first.
REQ-012 miso_oe  out  1  miso drive enable.
REQ-013 rx_data  out  WIDTH  last complete received word.
REQ-014 rx_valid  out  1  one-cycle strobe; rx_data updated.
REQ-015 rx_first  out  1  qualifies rx_valid; word is first of frame.
REQ-016 tx_data  in  WIDTH  next word to transmit.
REQ-017 tx_valid  in  1  tx_data holds a word.
REQ-018 tx_ready  out  1  one-cycle load strobe; word accepted if tx_valid high in the same cycle.
REQ-019 tx_underrun  out  1  one-cycle strobe; load occurred with tx_valid low.
REQ-020 frame_active  out  1  high while a frame is in progress.
REQ-021 frame_err  out  1  one-cycle strobe; cs_n deasserted mid-word.

Function
REQ-022 spi_clk, mosi and cs_n SHALL pass through SYNC_STAGES flops each, keeping equal latency; synchroniser reset values are spi_clk=CPOL, cs_n=1, mosi=0.
REQ-023 Leading edge SHALL be the synced rising edge when CPOL=0 and the falling edge when CPOL=1; trailing edge is the opposite edge.
REQ-024 The sample edge SHALL be the leading edge when CPHA=0 and the trailing edge when CPHA=1; the shift edge is the other edge.
REQ-025 FSM SHALL have states IDLE and ACTIVE; IDLE->ACTIVE on a synced cs_n 1->0 transition while armed; ACTIVE->IDLE on synced cs_n high.
REQ-026 The armed flag SHALL clear on reset and set once synced cs_n is seen high, so that cs_n held low through reset release never starts a frame.
REQ-027 On entering ACTIVE, bit_cnt SHALL be set to 0 and the first-word flag set; if CPHA=0, a tx load occurs in the same cycle.
REQ-028 On each sample edge in ACTIVE, rx shift SHALL take synced mosi into its LSB and bit_cnt SHALL increment.
REQ-029 On the sample edge where bit_cnt==WIDTH-1: rx_data <= full word, rx_valid=1 and rx_first=first-word flag on the next cycle, bit_cnt <= 0, and the first-word flag clears.
REQ-030 On each shift edge in ACTIVE: if bit_cnt==0, a tx load occurs; otherwise tx shift moves left one bit with 0 fill.
REQ-031 Tx load SHALL pulse tx_ready and load tx_data if tx_valid, else load all zeros and pulse tx_underrun.
REQ-032 miso SHALL equal tx shift MSB while ACTIVE and 0 in IDLE; miso_oe and frame_active SHALL equal (state==ACTIVE).
REQ-033 Multiple words per frame SHALL be supported back-to-back with no dead bits between words.
REQ-034 Synced cs_n high with bit_cnt!=0 SHALL pulse frame_err, discard the partial word and produce no rx_valid.
REQ-035 If cs_n deassertion and an spi_clk edge are seen in the same cycle, deassertion SHALL take priority and the edge is ignored.
REQ-036 spi_clk edges in IDLE SHALL be ignored; rx_data SHALL hold its value until the next completed word.

Reset
REQ-037 On rst_n low, outputs SHALL be asynchronously set to: rx_data=0, rx_valid=0, rx_first=0, tx_ready=0, tx_underrun=0, frame_err=0, miso=0, miso_oe=0, frame_active=0; state=IDLE, bit_cnt=0, armed=0.
REQ-038 Reset asserted mid-frame SHALL abandon the frame without a frame_err pulse; after release, the next frame requires cs_n to go high and then low.

Verification
REQ-039 WIDTH=8, mode 0: one frame, mosi 0xA5, tx_data 0x3C valid -> rx_data=0xA5, rx_valid and rx_first high for one cycle; controller reads 0x3C; one tx_ready pulse.
REQ-040 WIDTH=16, mode 3: three-word frame 0x1234, 0xBEEF, 0x0001 -> three rx_valid pulses, rx_first only on the first; tx words returned in order.
REQ-041 Mode 1: tx_valid low throughout -> miso reads 0x00, one tx_underrun per word, rx unaffected.
REQ-042 cs_n raised after 5 of 8 bits -> one frame_err pulse, no rx_valid, rx_data unchanged; the next full frame receives correctly.
REQ-043 cs_n held low while rst_n is released, then spi_clk toggled -> no rx_valid; after a cs_n high->low, the frame is received.
REQ-044 rst_n pulsed low after 3 bits -> all outputs 0 immediately, no frame_err; a subsequent full frame is received correctly.

Source files
------------

// File: rtl/spi_client_framed.sv
// SPI client with framed multi-word transfers: synchronises the SPI pins into clk,
// assembles WIDTH-bit words MSB first and streams tx words back on miso.
module spi_client_framed #(
    parameter int WIDTH       = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spi_clk,
    input  logic             mosi,
    input  logic             cs_n,
    output logic             miso,
    output logic             miso_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             rx_first,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_underrun,
    output logic             frame_active,
    output logic             frame_err
);

    localparam int             CW           = $clog2(WIDTH);
    localparam int             TOP          = SYNC_STAGES - 1;
    localparam logic           IDLE_LVL     = (CPOL != 0) ? 1'b1 : 1'b0;
    localparam logic           SAMPLE_TRAIL = (CPHA != 0) ? 1'b1 : 1'b0;
    localparam logic [CW-1:0]  LAST_BIT     = CW'(WIDTH - 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_r, cs_sync_r, mosi_sync_r, fill_r;
    logic                   sclk_d_r, cs_d_r, armed_r;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   rise_s, fall_s, lead_s, trail_s, sample_s, shift_s;

    state_t                 state_r, state_s;
    logic [CW-1:0]          bit_cnt_r, bit_cnt_s;
    logic                   first_r, first_s;
    logic [WIDTH-1:0]       rx_shift_r, rx_shift_s;
    logic [WIDTH-1:0]       tx_shift_r, tx_shift_s;
    logic                   load_s, done_s, ferr_s;

    logic [WIDTH-1:0]       rx_data_r;
    logic                   rx_valid_r, rx_first_r, tx_underrun_r, frame_err_r;
    logic                   miso_r, active_r;

    // Equal-depth synchronisers; fill_r marks when the chain holds real pin samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_r <= {SYNC_STAGES{IDLE_LVL}};
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            fill_r      <= {SYNC_STAGES{1'b0}};
        end else begin
            sclk_sync_r <= {sclk_sync_r[TOP-1:0], spi_clk};
            cs_sync_r   <= {cs_sync_r[TOP-1:0], cs_n};
            mosi_sync_r <= {mosi_sync_r[TOP-1:0], mosi};
            fill_r      <= {fill_r[TOP-1:0], 1'b1};
        end
    end

    assign sclk_s = sclk_sync_r[TOP];
    assign cs_s   = cs_sync_r[TOP];
    assign mosi_s = mosi_sync_r[TOP];

    // Edge-detect history and arming; reset values of the chain never arm the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d_r <= IDLE_LVL;
            cs_d_r   <= 1'b1;
            armed_r  <= 1'b0;
        end else begin
            sclk_d_r <= sclk_s;
            cs_d_r   <= cs_s;
            if (fill_r[TOP] && cs_s) begin
                armed_r <= 1'b1;
            end
        end
    end

    assign rise_s   = sclk_s & ~sclk_d_r;
    assign fall_s   = ~sclk_s & sclk_d_r;
    assign lead_s   = IDLE_LVL ? fall_s : rise_s;
    assign trail_s  = IDLE_LVL ? rise_s : fall_s;
    assign sample_s = SAMPLE_TRAIL ? trail_s : lead_s;
    assign shift_s  = SAMPLE_TRAIL ? lead_s : trail_s;

    // Frame FSM and datapath next-state; cs_n deassertion outranks any clock edge.
    always_comb begin
        state_s    = state_r;
        bit_cnt_s  = bit_cnt_r;
        first_s    = first_r;
        rx_shift_s = rx_shift_r;
        tx_shift_s = tx_shift_r;
        load_s     = 1'b0;
        done_s     = 1'b0;
        ferr_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (armed_r && cs_d_r && !cs_s) begin
                    state_s    = ST_ACTIVE;
                    bit_cnt_s  = '0;
                    first_s    = 1'b1;
                    tx_shift_s = '0;
                    load_s     = !SAMPLE_TRAIL;
                end else begin
                    bit_cnt_s = '0;
                end
            end
            ST_ACTIVE: begin
                if (cs_s) begin
                    state_s   = ST_IDLE;
                    ferr_s    = (bit_cnt_r != '0);
                    bit_cnt_s = '0;
                end else if (sample_s) begin
                    rx_shift_s = {rx_shift_r[WIDTH-2:0], mosi_s};
                    if (bit_cnt_r == LAST_BIT) begin
                        done_s    = 1'b1;
                        bit_cnt_s = '0;
                        first_s   = 1'b0;
                    end else begin
                        bit_cnt_s = bit_cnt_r + CW'(1);
                    end
                end else if (shift_s) begin
                    if (bit_cnt_r == '0) begin
                        load_s = 1'b1;
                    end else begin
                        tx_shift_s = {tx_shift_r[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    state_s = ST_ACTIVE;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                bit_cnt_s = '0;
            end
        endcase
        tx_shift_s = load_s ? (tx_valid ? tx_data : '0) : tx_shift_s;
    end

    // State, shift registers and registered output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            bit_cnt_r     <= '0;
            first_r       <= 1'b0;
            rx_shift_r    <= '0;
            tx_shift_r    <= '0;
            rx_data_r     <= '0;
            rx_valid_r    <= 1'b0;
            rx_first_r    <= 1'b0;
            tx_underrun_r <= 1'b0;
            frame_err_r   <= 1'b0;
            miso_r        <= 1'b0;
            active_r      <= 1'b0;
        end else begin
            state_r       <= state_s;
            bit_cnt_r     <= bit_cnt_s;
            first_r       <= first_s;
            rx_shift_r    <= rx_shift_s;
            tx_shift_r    <= tx_shift_s;
            if (done_s) begin
                rx_data_r <= rx_shift_s;
            end
            rx_valid_r    <= done_s;
            rx_first_r    <= done_s & first_r;
            tx_underrun_r <= load_s & ~tx_valid;
            frame_err_r   <= ferr_s;
            miso_r        <= (state_s == ST_ACTIVE) & tx_shift_s[WIDTH-1];
            active_r      <= (state_s == ST_ACTIVE);
        end
    end

    // tx_ready is combinational so it coincides with the cycle tx_data is captured.
    assign tx_ready     = load_s;
    assign miso         = miso_r;
    assign miso_oe      = active_r;
    assign frame_active = active_r;
    assign rx_data      = rx_data_r;
    assign rx_valid     = rx_valid_r;
    assign rx_first     = rx_first_r;
    assign tx_underrun  = tx_underrun_r;
    assign frame_err    = frame_err_r;

endmodule

// File: tb/tb_spi_client_framed.sv
// Directed bench for spi_client_framed: three instances (mode 0 x8, mode 3 x16, mode 1 x8)
// driven by a behavioural SPI controller, with table vectors plus reset corner sequences.
module tb_spi_client_framed;

    typedef struct {
        int          d;
        int          nw;
        int          stop;
        logic [31:0] mo0, mo1, mo2;
        logic [31:0] tx0, tx1, tx2;
        logic        vld;
        int          e_rx;
        int          e_rdy;
        int          e_und;
        int          e_ferr;
        logic [31:0] e_rxd;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        sclk [3];
    logic        mosi_v [3];
    logic        csn [3];
    logic        txv [3];
    logic [7:0]  txd0, txd2;
    logic [15:0] txd1;
    logic        miso_v [3], oe [3], fa [3], rxv [3], rxf [3], txr [3], txu [3], ferr [3];
    logic [7:0]  rxd0, rxd2;
    logic [15:0] rxd1;

    int          n_chk = 0;
    int          n_err = 0;
    int          rx_cnt [3] = '{0, 0, 0};
    int          rdy_cnt [3] = '{0, 0, 0};
    int          und_cnt [3] = '{0, 0, 0};
    int          ferr_cnt [3] = '{0, 0, 0};
    logic [31:0] rx_log [3][8];
    logic        fst_log [3][8];

    logic [31:0] mo_w [3];
    logic [31:0] tx_w [3];
    logic [31:0] mi_w [3];
    logic        tx_vld;
    vec_t        vecs [7];

    spi_client_framed #(.WIDTH(8), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) u0 (
        .clk(clk), .rst_n(rst_n), .spi_clk(sclk[0]), .mosi(mosi_v[0]), .cs_n(csn[0]),
        .miso(miso_v[0]), .miso_oe(oe[0]), .rx_data(rxd0), .rx_valid(rxv[0]), .rx_first(rxf[0]),
        .tx_data(txd0), .tx_valid(txv[0]), .tx_ready(txr[0]), .tx_underrun(txu[0]),
        .frame_active(fa[0]), .frame_err(ferr[0]));

    spi_client_framed #(.WIDTH(16), .CPOL(1), .CPHA(1), .SYNC_STAGES(3)) u1 (
        .clk(clk), .rst_n(rst_n), .spi_clk(sclk[1]), .mosi(mosi_v[1]), .cs_n(csn[1]),
        .miso(miso_v[1]), .miso_oe(oe[1]), .rx_data(rxd1), .rx_valid(rxv[1]), .rx_first(rxf[1]),
        .tx_data(txd1), .tx_valid(txv[1]), .tx_ready(txr[1]), .tx_underrun(txu[1]),
        .frame_active(fa[1]), .frame_err(ferr[1]));

    spi_client_framed #(.WIDTH(8), .CPOL(0), .CPHA(1), .SYNC_STAGES(2)) u2 (
        .clk(clk), .rst_n(rst_n), .spi_clk(sclk[2]), .mosi(mosi_v[2]), .cs_n(csn[2]),
        .miso(miso_v[2]), .miso_oe(oe[2]), .rx_data(rxd2), .rx_valid(rxv[2]), .rx_first(rxf[2]),
        .tx_data(txd2), .tx_valid(txv[2]), .tx_ready(txr[2]), .tx_underrun(txu[2]),
        .frame_active(fa[2]), .frame_err(ferr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int w_of(input int d);
        return (d == 1) ? 16 : 8;
    endfunction

    function automatic logic pol_of(input int d);
        return (d == 1) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic pha_of(input int d);
        return (d != 0) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic [31:0] get_rxd(input int d);
        case (d)
            0:       return {24'd0, rxd0};
            1:       return {16'd0, rxd1};
            default: return {24'd0, rxd2};
        endcase
    endfunction

    function automatic logic [7:0] out_bits(input int d);
        return {rxv[d], rxf[d], txr[d], txu[d], ferr[d], miso_v[d], oe[d], fa[d]};
    endfunction

    // Strobe monitor: counts pulses and logs received words per instance.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rxv[d]) begin
                rx_log[d][rx_cnt[d] % 8]  <= get_rxd(d);
                fst_log[d][rx_cnt[d] % 8] <= rxf[d];
                rx_cnt[d]                 <= rx_cnt[d] + 1;
            end
            if (txr[d])  rdy_cnt[d]  <= rdy_cnt[d] + 1;
            if (txu[d])  und_cnt[d]  <= und_cnt[d] + 1;
            if (ferr[d]) ferr_cnt[d] <= ferr_cnt[d] + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic half();
        repeat (4) @(negedge clk);
    endtask

    task automatic set_tx(input int d, input logic [31:0] v, input logic vld);
        case (d)
            0:       txd0 = v[7:0];
            1:       txd1 = v[15:0];
            default: txd2 = v[7:0];
        endcase
        txv[d] = vld;
    endtask

    // Controller: stop<0 runs nw full words; otherwise stops after 'stop' bits.
    task automatic run_frame(input int d, input int nw, input int stop, input bit raise);
        int   w;
        int   total;
        logic pol;
        logic pha;
        w     = w_of(d);
        pol   = pol_of(d);
        pha   = pha_of(d);
        total = (stop < 0) ? nw * w : stop;
        for (int k = 0; k < 3; k++) mi_w[k] = 32'd0;
        set_tx(d, tx_w[0], tx_vld);
        csn[d] = 1'b0;
        if (!pha) mosi_v[d] = mo_w[0][w-1];
        for (int b = 0; b < total; b++) begin
            int k;
            int i;
            k = b / w;
            i = w - 1 - (b % w);
            half();
            if (!pha) mi_w[k] = {mi_w[k][30:0], miso_v[d]};
            else mosi_v[d] = mo_w[k][i];
            sclk[d] = ~pol;
            half();
            if (pha) mi_w[k] = {mi_w[k][30:0], miso_v[d]};
            sclk[d] = pol;
            if (!pha && (b + 1 < total)) mosi_v[d] = mo_w[(b + 1) / w][w - 1 - ((b + 1) % w)];
            if ((b % w == 1) && (k + 1 < 3)) set_tx(d, tx_w[k+1], tx_vld);
            if (!pha && raise && (b + 1 == total)) csn[d] = 1'b1;
        end
        if (pha && raise) begin
            half();
            csn[d] = 1'b1;
        end
        half();
        half();
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        int          b_rx, b_rdy, b_und, b_ferr;
        logic [31:0] exp_mi;
        mo_w[0] = v.mo0; mo_w[1] = v.mo1; mo_w[2] = v.mo2;
        tx_w[0] = v.tx0; tx_w[1] = v.tx1; tx_w[2] = v.tx2;
        tx_vld  = v.vld;
        b_rx    = rx_cnt[v.d];
        b_rdy   = rdy_cnt[v.d];
        b_und   = und_cnt[v.d];
        b_ferr  = ferr_cnt[v.d];
        run_frame(v.d, v.nw, v.stop, 1'b1);
        chk({tag, "_rxcnt"}, 32'(rx_cnt[v.d] - b_rx), 32'(v.e_rx));
        for (int k = 0; k < v.e_rx && k < 3; k++) begin
            chk($sformatf("%s_rxword%0d", tag, k), rx_log[v.d][(b_rx + k) % 8], mo_w[k]);
            chk($sformatf("%s_rxfirst%0d", tag, k), 32'(fst_log[v.d][(b_rx + k) % 8]),
                (k == 0) ? 32'd1 : 32'd0);
        end
        chk({tag, "_txready"}, 32'(rdy_cnt[v.d] - b_rdy), 32'(v.e_rdy));
        chk({tag, "_underrun"}, 32'(und_cnt[v.d] - b_und), 32'(v.e_und));
        chk({tag, "_frameerr"}, 32'(ferr_cnt[v.d] - b_ferr), 32'(v.e_ferr));
        if (v.stop < 0) begin
            for (int k = 0; k < v.nw; k++) begin
                exp_mi = v.vld ? tx_w[k] : 32'd0;
                chk($sformatf("%s_miso%0d", tag, k), mi_w[k], exp_mi);
            end
        end
        chk({tag, "_rxdata"}, get_rxd(v.d), v.e_rxd);
        chk({tag, "_idle"}, {31'd0, fa[v.d]}, 32'd0);
    endtask

    initial begin
        vec_t v;
        int   b_rx, b_rdy, b_ferr;

        vecs[0] = '{0, 1, -1, 32'hA5, 32'h0, 32'h0, 32'h3C, 32'h0, 32'h0, 1'b1, 1, 1, 0, 0, 32'hA5};
        vecs[1] = '{0, 1, -1, 32'h0F, 32'h0, 32'h0, 32'hF0, 32'h0, 32'h0, 1'b1, 1, 1, 0, 0, 32'h0F};
        vecs[2] = '{0, 1, 5, 32'h33, 32'h0, 32'h0, 32'h99, 32'h0, 32'h0, 1'b1, 0, 1, 0, 1, 32'h0F};
        vecs[3] = '{0, 1, -1, 32'hC3, 32'h0, 32'h0, 32'h5A, 32'h0, 32'h0, 1'b1, 1, 1, 0, 0, 32'hC3};
        vecs[4] = '{1, 3, -1, 32'h1234, 32'hBEEF, 32'h0001, 32'hCAFE, 32'h8001, 32'h7E5A,
                    1'b1, 3, 3, 0, 0, 32'h0001};
        vecs[5] = '{2, 2, -1, 32'h96, 32'h01, 32'h0, 32'hAA, 32'hBB, 32'h0, 1'b0, 2, 2, 2, 0, 32'h01};
        vecs[6] = '{2, 1, -1, 32'h80, 32'h0, 32'h0, 32'h7F, 32'h0, 32'h0, 1'b1, 1, 1, 0, 0, 32'h80};

        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            sclk[d]   = pol_of(d);
            mosi_v[d] = 1'b0;
            csn[d]    = 1'b1;
            txv[d]    = 1'b0;
        end
        txd0 = 8'd0; txd1 = 16'd0; txd2 = 8'd0;
        repeat (5) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_out%0d", d), {24'd0, out_bits(d)}, 32'd0);
            chk($sformatf("reset_rxdata%0d", d), get_rxd(d), 32'd0);
        end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // cs_n held low through reset release must not start a frame.
        csn[0] = 1'b0;
        half();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        b_rx  = rx_cnt[0];
        b_rdy = rdy_cnt[0];
        for (int i = 0; i < 8; i++) begin
            mosi_v[0] = i[0];
            half();
            sclk[0] = 1'b1;
            half();
            sclk[0] = 1'b0;
        end
        half();
        chk("unarmed_rxcnt", 32'(rx_cnt[0] - b_rx), 32'd0);
        chk("unarmed_txready", 32'(rdy_cnt[0] - b_rdy), 32'd0);
        chk("unarmed_out", {24'd0, out_bits(0)}, 32'd0);
        csn[0] = 1'b1;
        repeat (8) @(negedge clk);
        v = '{0, 1, -1, 32'h6E, 32'h0, 32'h0, 32'h11, 32'h0, 32'h0, 1'b1, 1, 1, 0, 0, 32'h6E};
        apply_vec(v, "rearm");

        // Reset pulse after 3 bits abandons the frame silently.
        mo_w[0] = 32'hFF; tx_w[0] = 32'h81; tx_vld = 1'b1;
        run_frame(0, 1, 3, 1'b0);
        chk("midframe_active", {31'd0, fa[0]}, 32'd1);
        b_ferr = ferr_cnt[0];
        rst_n = 1'b0;
        #1;
        chk("midreset_out", {24'd0, out_bits(0)}, 32'd0);
        chk("midreset_rxdata", get_rxd(0), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midreset_frameerr", 32'(ferr_cnt[0] - b_ferr), 32'd0);
        chk("midreset_idle", {31'd0, fa[0]}, 32'd0);
        csn[0] = 1'b1;
        repeat (8) @(negedge clk);
        v = '{0, 1, -1, 32'hB4, 32'h0, 32'h0, 32'h2D, 32'h0, 32'h0, 1'b1, 1, 1, 0, 0, 32'hB4};
        apply_vec(v, "postreset");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
